cpu0_oci_dct_arbiter: RTL and testbench

CPU0_OCI_DCT_ARBITER -- requirements
Module: cpu0_oci_dct_arbiter

---
 rtl/cpu0_oci_dct_arbiter.sv | 80 ++++++++
 tb/tb_cpu0_oci_dct_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu0_oci_dct_arbiter.sv
// cpu0_oci_dct_arbiter: arbitrates two 2-bit trace atom sources into a 15-atom packing buffer and launches packed frames
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   trace_enable               gates all grants
//   req_a/atom_a, req_b/atom_b requesters; gnt_a/gnt_b combinational grants
//   flush                      pulse requesting launch of a partial buffer
//   out_valid/out_ready        frame handshake; out_data/out_count hold the frame
//   dct_buffer/dct_count       live packing buffer and its atom count
module cpu0_oci_dct_arbiter #(
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trace_enable,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [1:0]  atom_a,
  input  logic [1:0]  atom_b,
  output logic        gnt_a,
  output logic        gnt_b,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [29:0] out_data,
  output logic [3:0]  out_count,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count
);
  logic       flush_pend;
  logic       last_b;
  logic [7:0] idle_cnt;
  logic       reg_free;
  logic       launch;
  logic       accept_ok;
  logic       accept;
  logic [1:0] atom;
  always_comb begin
    reg_free  = !out_valid || out_ready;
    launch    = reg_free && dct_count != 4'd0 &&
                (dct_count == 4'd15 || flush_pend || idle_cnt == 8'(IDLE_TIMEOUT));
    // reset_n gates grants so nothing is offered while reset is held
    accept_ok = reset_n && trace_enable && dct_count != 4'd15 && !launch;
    gnt_a     = accept_ok && req_a && (!req_b || last_b);
    gnt_b     = accept_ok && req_b && !gnt_a;
    accept    = gnt_a || gnt_b;
    atom      = gnt_a ? atom_a : atom_b;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_count  <= '0;
      dct_buffer <= '0;
      dct_count  <= '0;
      flush_pend <= 1'b0;
      idle_cnt   <= '0;
      last_b     <= 1'b1;
    end else if (launch) begin
      out_valid  <= 1'b1;
      out_data   <= dct_buffer;
      out_count  <= dct_count;
      dct_buffer <= '0;
      dct_count  <= '0;
      flush_pend <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        dct_buffer <= dct_buffer | (30'(atom) << {dct_count, 1'b0});
        dct_count  <= dct_count + 4'd1;
        last_b     <= gnt_b;
        idle_cnt   <= '0;
      end else if (dct_count != 4'd0 && idle_cnt < 8'(IDLE_TIMEOUT)) begin
        idle_cnt <= idle_cnt + 8'd1;
      end
      // a flush seen while the buffer is empty and nothing arrives is dropped
      flush_pend <= (dct_count == 4'd0 && !accept) ? 1'b0 : (flush_pend || flush);
    end
  end
endmodule

// File: tb/tb_cpu0_oci_dct_arbiter.sv
// tb_cpu0_oci_dct_arbiter: table vectors, directed corner sequences and random traffic against a queue-based model
module tb_cpu0_oci_dct_arbiter;
  localparam int TO = 16;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        trace_enable = 1'b0;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic [1:0]  atom_a = 2'd0;
  logic [1:0]  atom_b = 2'd0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        gnt_a, gnt_b, out_valid;
  logic [29:0] out_data, dct_buffer;
  logic [3:0]  out_count, dct_count;

  cpu0_oci_dct_arbiter #(.IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .trace_enable(trace_enable),
    .req_a(req_a), .req_b(req_b), .atom_a(atom_a), .atom_b(atom_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_count(out_count),
    .dct_buffer(dct_buffer), .dct_count(dct_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  // reference model: the buffer is an ordered list of atoms
  int          q[$];
  bit          m_ov, m_fp, m_last_a;
  logic [29:0] m_od;
  int          m_oc, m_idle;
  bit          seen_ga, seen_gb;

  typedef struct {
    bit en, ra, rb;
    logic [1:0] aa, ab;
    bit fl, rdy;
    bit ga, gb;
    logic [3:0] cnt;
    logic [29:0] bufv;
    bit ov;
    logic [3:0] oc;
  } vec_t;
  vec_t tbl[6];

  function automatic logic [29:0] pack_q();
    logic [29:0] v = '0;
    foreach (q[i]) v |= 30'(q[i]) << (2 * i);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ov = 0; m_fp = 0; m_last_a = 0; m_od = '0; m_oc = 0; m_idle = 0;
  endtask

  task automatic chk_outputs_zero();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_count", 32'(out_count), 0);
    chk("rst_dct_buffer", 32'(dct_buffer), 0);
    chk("rst_dct_count", 32'(dct_count), 0);
    chk("rst_gnt_a", 32'(gnt_a), 0);
    chk("rst_gnt_b", 32'(gnt_b), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk_outputs_zero();
    repeat (2) @(posedge clk);
    #1;
    trace_enable = 0; req_a = 0; req_b = 0; flush = 0;
    reset_n = 1'b1;
  endtask

  // one clock cycle: drive, check grants, clock, check registered state
  task automatic cyc(input bit en, input bit ra, input bit rb, input logic [1:0] aa,
                     input logic [1:0] ab, input bit fl, input bit rdy);
    bit free, launch, ok, wa, wb;
    int n;
    trace_enable = en; req_a = ra; req_b = rb; atom_a = aa; atom_b = ab;
    flush = fl; out_ready = rdy;
    #1;
    n = q.size();
    free = !m_ov || rdy;
    launch = free && n > 0 && (n == 15 || m_fp || m_idle == TO);
    ok = en && n < 15 && !launch;
    wa = ok && ra && (!rb || !m_last_a);
    wb = ok && rb && !wa;
    chk("gnt_a", 32'(gnt_a), 32'(wa));
    chk("gnt_b", 32'(gnt_b), 32'(wb));
    seen_ga = gnt_a; seen_gb = gnt_b;
    @(posedge clk);
    if (launch) begin
      m_ov = 1; m_od = pack_q(); m_oc = n;
      q.delete(); m_fp = 0; m_idle = 0;
    end else begin
      if (m_ov && rdy) m_ov = 0;
      if (wa || wb) begin
        q.push_back(wa ? int'(aa) : int'(ab));
        m_last_a = wa;
        m_idle = 0;
      end else if (n > 0 && m_idle < TO) m_idle++;
      if (n == 0 && !(wa || wb)) m_fp = 0;
      else if (fl) m_fp = 1;
    end
    #1;
    chk("dct_count", 32'(dct_count), 32'(q.size()));
    chk("dct_buffer", 32'(dct_buffer), 32'(pack_q()));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data", 32'(out_data), 32'(m_od));
    chk("out_count", 32'(out_count), 32'(m_oc));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int first_ov;
    logic [29:0] held;
    out_ready = 1'b1;
    tbl[0] = '{1, 1, 1, 2'd1, 2'd2, 0, 1, 1, 0, 4'd1, 30'h01, 0, 4'd0};
    tbl[1] = '{1, 1, 1, 2'd1, 2'd2, 0, 1, 0, 1, 4'd2, 30'h09, 0, 4'd0};
    tbl[2] = '{1, 1, 1, 2'd1, 2'd2, 0, 1, 1, 0, 4'd3, 30'h19, 0, 4'd0};
    tbl[3] = '{0, 1, 1, 2'd1, 2'd2, 1, 1, 0, 0, 4'd3, 30'h19, 0, 4'd0};
    tbl[4] = '{0, 0, 0, 2'd0, 2'd0, 0, 1, 0, 0, 4'd0, 30'h00, 1, 4'd3};
    tbl[5] = '{1, 1, 0, 2'd3, 2'd0, 0, 1, 1, 0, 4'd1, 30'h03, 0, 4'd3};

    // table vectors: alternating tie grants, then a flush-driven launch
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(tbl[i].en, tbl[i].ra, tbl[i].rb, tbl[i].aa, tbl[i].ab, tbl[i].fl, tbl[i].rdy);
      chk($sformatf("v%0d_gnt_a", i), 32'(seen_ga), 32'(tbl[i].ga));
      chk($sformatf("v%0d_gnt_b", i), 32'(seen_gb), 32'(tbl[i].gb));
      chk($sformatf("v%0d_count", i), 32'(dct_count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_buffer", i), 32'(dct_buffer), 32'(tbl[i].bufv));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("v%0d_out_count", i), 32'(out_count), 32'(tbl[i].oc));
    end
    chk("v4_frame", 32'(out_data), 32'h19);

    // fill to FULL; launch on the following edge
    do_reset();
    for (int i = 0; i < 15; i++) begin
      cyc(1, 1, 0, 2'd1, 2'd0, 0, 1);
      chk("fill_count", 32'(dct_count), 32'(i + 1));
    end
    cyc(1, 1, 0, 2'd1, 2'd0, 0, 1);
    chk("full_out_valid", 32'(out_valid), 1);
    chk("full_out_data", 32'(out_data), 32'h15555555);
    chk("full_out_count", 32'(out_count), 15);
    chk("full_dct_count", 32'(dct_count), 0);

    // flush with stalled output
    do_reset();
    repeat (3) cyc(1, 1, 0, 2'd1, 2'd0, 0, 0);
    cyc(1, 0, 0, 2'd0, 2'd0, 1, 0);
    cyc(1, 0, 0, 2'd0, 2'd0, 0, 0);
    chk("flush_out_valid", 32'(out_valid), 1);
    chk("flush_out_count", 32'(out_count), 3);
    chk("flush_out_data", 32'(out_data), 32'h15);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 2'd0, 2'd0, 0, 0);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_data", 32'(out_data), 32'(held));
      chk("stall_count", 32'(out_count), 3);
    end
    cyc(1, 0, 0, 2'd0, 2'd0, 0, 1);
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_data_hold", 32'(out_data), 32'(held));

    // idle timeout: counter reaches TO on edge N+TO, launch registers on the next edge
    do_reset();
    cyc(1, 0, 1, 2'd0, 2'd3, 0, 1);
    first_ov = 0;
    for (int i = 1; i <= 40 && first_ov == 0; i++) begin
      cyc(1, 0, 0, 2'd0, 2'd0, 0, 1);
      if (out_valid) first_ov = i;
    end
    chk("timeout_edges", 32'(first_ov), 32'(TO + 1));
    chk("timeout_out_count", 32'(out_count), 1);
    chk("timeout_out_data", 32'(out_data), 32'h3);

    // FULL while the output register is busy
    do_reset();
    repeat (16) cyc(1, 1, 0, 2'd1, 2'd0, 0, 0);
    chk("busy_first_frame", 32'(out_valid), 1);
    repeat (15) cyc(1, 1, 1, 2'd2, 2'd3, 0, 0);
    chk("busy_full", 32'(dct_count), 15);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 1, 2'd2, 2'd3, 0, 0);
      chk("busy_gnt_a", 32'(seen_ga), 0);
      chk("busy_gnt_b", 32'(seen_gb), 0);
      chk("busy_hold", 32'(dct_count), 15);
    end
    cyc(1, 1, 1, 2'd2, 2'd3, 0, 1);
    chk("busy_launch_valid", 32'(out_valid), 1);
    chk("busy_launch_count", 32'(out_count), 15);
    chk("busy_launch_dct", 32'(dct_count), 0);

    // empty flush and mid-frame reset never produce a frame
    do_reset();
    cyc(1, 0, 0, 2'd0, 2'd0, 1, 1);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0, 2'd0, 2'd0, 0, 1);
      chk("empty_flush_no_frame", 32'(out_valid), 0);
    end
    repeat (7) cyc(1, 1, 0, 2'd2, 2'd0, 0, 1);
    chk("pre_reset_count", 32'(dct_count), 7);
    trace_enable = 1; req_a = 1; req_b = 1;
    #2;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0, 2'd0, 2'd0, (i == 0), 1);
      chk("post_reset_no_frame", 32'(out_valid), 0);
    end

    // random traffic in phases of differing request density
    do_reset();
    for (int ph = 0; ph < 15; ph++) begin
      int p_req, p_rdy;
      p_req = $urandom_range(5, 95);
      p_rdy = $urandom_range(10, 100);
      for (int i = 0; i < 200; i++)
        cyc($urandom_range(0, 99) < 90, $urandom_range(0, 99) < p_req,
            $urandom_range(0, 99) < p_req, 2'($urandom), 2'($urandom),
            $urandom_range(0, 99) < 4, $urandom_range(0, 99) < p_rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
